// File: rtl/apb_rr_arbiter.sv
// Two-requester round-robin front end for a single APB master port.
// Requests are accepted only in IDLE; an ACCESS phase is aborted with slverr after TIMEOUT cycles.
//
// state  | meaning
// IDLE   | bus free, arbitrate and accept one request
// SETUP  | APB setup phase, sel=1 enable=0
// ACCESS | APB access phase, waiting for ready or timeout
module apb_rr_arbiter #(
  parameter int AWIDTH  = 12,
  parameter int DWIDTH  = 32,
  parameter int SWIDTH  = DWIDTH / 8,
  parameter int TIMEOUT = 16
) (
  input  logic                i_ck,
  input  logic                i_rst_n,
  input  logic [1:0]          i_req_valid,
  output logic [1:0]          o_req_ready,
  input  logic [2*AWIDTH-1:0] i_req_addr,
  input  logic [1:0]          i_req_write,
  input  logic [2*DWIDTH-1:0] i_req_wdata,
  input  logic [2*SWIDTH-1:0] i_req_strb,
  input  logic [5:0]          i_req_prot,
  output logic [1:0]          o_rsp_valid,
  output logic [DWIDTH-1:0]   o_rsp_rdata,
  output logic                o_rsp_slverr,
  output logic                o_sel,
  output logic                o_enable,
  output logic [AWIDTH-1:0]   o_addr,
  output logic                o_write,
  output logic [DWIDTH-1:0]   o_wdata,
  output logic [SWIDTH-1:0]   o_strb,
  output logic [2:0]          o_prot,
  input  logic [DWIDTH-1:0]   i_rdata,
  input  logic                i_ready,
  input  logic                i_slverr
);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] SETUP  = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;

  logic [1:0] state;
  logic       last_gnt;
  logic       gnt_any;
  logic       gnt_sel;
  logic [7:0] wait_cnt;
  logic       abort;

  // On a tie the requester that was not granted last wins.
  always_comb begin
    gnt_any = (state == IDLE) && (i_req_valid != 2'b00);
    case (i_req_valid)
      2'b01:   gnt_sel = 1'b0;
      2'b10:   gnt_sel = 1'b1;
      default: gnt_sel = ~last_gnt;
    endcase
  end

  assign o_req_ready = gnt_any ? (gnt_sel ? 2'b10 : 2'b01) : 2'b00;
  assign abort       = (wait_cnt == 8'(TIMEOUT - 1)) && !i_ready;

  always_ff @(posedge i_ck or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      last_gnt     <= 1'b1;
      wait_cnt     <= '0;
      o_sel        <= 1'b0;
      o_enable     <= 1'b0;
      o_addr       <= '0;
      o_write      <= 1'b0;
      o_wdata      <= '0;
      o_strb       <= '0;
      o_prot       <= '0;
      o_rsp_valid  <= 2'b00;
      o_rsp_rdata  <= '0;
      o_rsp_slverr <= 1'b0;
    end else begin
      o_rsp_valid  <= 2'b00;
      o_rsp_rdata  <= '0;
      o_rsp_slverr <= 1'b0;
      case (state)
        IDLE: begin
          if (gnt_any) begin
            state    <= SETUP;
            last_gnt <= gnt_sel;
            o_sel    <= 1'b1;
            o_enable <= 1'b0;
            o_addr   <= gnt_sel ? i_req_addr[2*AWIDTH-1:AWIDTH] : i_req_addr[AWIDTH-1:0];
            o_write  <= gnt_sel ? i_req_write[1] : i_req_write[0];
            o_wdata  <= gnt_sel ? i_req_wdata[2*DWIDTH-1:DWIDTH] : i_req_wdata[DWIDTH-1:0];
            o_strb   <= gnt_sel ? i_req_strb[2*SWIDTH-1:SWIDTH] : i_req_strb[SWIDTH-1:0];
            o_prot   <= gnt_sel ? i_req_prot[5:3] : i_req_prot[2:0];
          end
        end
        SETUP: begin
          state    <= ACCESS;
          o_enable <= 1'b1;
          wait_cnt <= '0;
        end
        ACCESS: begin
          if (i_ready || abort) begin
            state        <= IDLE;
            o_sel        <= 1'b0;
            o_enable     <= 1'b0;
            o_rsp_valid  <= last_gnt ? 2'b10 : 2'b01;
            o_rsp_rdata  <= (i_ready && !o_write) ? i_rdata : '0;
            o_rsp_slverr <= i_ready ? i_slverr : 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_apb_rr_arbiter.sv
// Directed bench for apb_rr_arbiter: transaction-level timeline model checked every cycle,
// plus literal expectations on logged grant/response events.
module tb_apb_rr_arbiter;
  localparam int AW = 12;
  localparam int DW = 32;
  localparam int SW = 4;
  localparam int TO = 4;

  logic            i_ck = 1'b0;
  logic            i_rst_n = 1'b0;
  logic [1:0]      i_req_valid;
  logic [1:0]      o_req_ready;
  logic [2*AW-1:0] i_req_addr;
  logic [1:0]      i_req_write;
  logic [2*DW-1:0] i_req_wdata;
  logic [2*SW-1:0] i_req_strb;
  logic [5:0]      i_req_prot;
  logic [1:0]      o_rsp_valid;
  logic [DW-1:0]   o_rsp_rdata;
  logic            o_rsp_slverr;
  logic            o_sel, o_enable, o_write;
  logic [AW-1:0]   o_addr;
  logic [DW-1:0]   o_wdata;
  logic [SW-1:0]   o_strb;
  logic [2:0]      o_prot;
  logic [DW-1:0]   i_rdata;
  logic            i_ready, i_slverr;

  apb_rr_arbiter #(.AWIDTH(AW), .DWIDTH(DW), .SWIDTH(SW), .TIMEOUT(TO)) dut (
    .i_ck(i_ck), .i_rst_n(i_rst_n),
    .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
    .i_req_addr(i_req_addr), .i_req_write(i_req_write), .i_req_wdata(i_req_wdata),
    .i_req_strb(i_req_strb), .i_req_prot(i_req_prot),
    .o_rsp_valid(o_rsp_valid), .o_rsp_rdata(o_rsp_rdata), .o_rsp_slverr(o_rsp_slverr),
    .o_sel(o_sel), .o_enable(o_enable), .o_addr(o_addr), .o_write(o_write),
    .o_wdata(o_wdata), .o_strb(o_strb), .o_prot(o_prot),
    .i_rdata(i_rdata), .i_ready(i_ready), .i_slverr(i_slverr)
  );

  always #5 i_ck = ~i_ck;

  typedef struct {
    logic [AW-1:0] addr;
    logic          write;
    logic [DW-1:0] wdata;
    logic [SW-1:0] strb;
    logic [2:0]    prot;
    int            waits;   // slave wait states before ready; >= TO means never ready
    logic [DW-1:0] rdata;
    logic          slverr;
  } txn_t;

  txn_t q0[$], q1[$];
  int   vectors = 0;
  int   errors = 0;
  int   cyc = 0;

  // model: one transfer at a time, timeline derived from accept cycle and wait count
  bit   act = 0;
  txn_t cur;
  int   cur_id, ta, acc_n, mlast = 1;
  bit   cur_to;

  // DUT-observed event logs
  int            g_id[$], g_cyc[$], r_cyc[$], r_en[$];
  logic [1:0]    r_vec[$];
  logic [DW-1:0] r_rd[$];
  logic          r_err[$];
  int            en_cnt = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, got, exp);
    end
  endtask

  function automatic txn_t mk(input logic [AW-1:0] a, input logic w, input logic [DW-1:0] wd,
                              input logic [SW-1:0] s, input logic [2:0] p, input int wt,
                              input logic [DW-1:0] rd, input logic e);
    txn_t t;
    t.addr = a; t.write = w; t.wdata = wd; t.strb = s; t.prot = p;
    t.waits = wt; t.rdata = rd; t.slverr = e;
    return t;
  endfunction

  task automatic step();
    logic [1:0] v, exp_rdy, exp_rsp;
    bit in_acc, exp_sel, exp_en, free;
    int win, k;
    txn_t t;
    v = {q1.size() > 0, q0.size() > 0};
    i_req_valid = v;
    i_req_addr  = (2*AW)'($urandom);
    i_req_write = 2'($urandom);
    i_req_wdata = {$urandom, $urandom};
    i_req_strb  = (2*SW)'($urandom);
    i_req_prot  = 6'($urandom);
    if (v[0]) begin
      i_req_addr[AW-1:0] = q0[0].addr; i_req_write[0] = q0[0].write;
      i_req_wdata[DW-1:0] = q0[0].wdata; i_req_strb[SW-1:0] = q0[0].strb;
      i_req_prot[2:0] = q0[0].prot;
    end
    if (v[1]) begin
      i_req_addr[2*AW-1:AW] = q1[0].addr; i_req_write[1] = q1[0].write;
      i_req_wdata[2*DW-1:DW] = q1[0].wdata; i_req_strb[2*SW-1:SW] = q1[0].strb;
      i_req_prot[5:3] = q1[0].prot;
    end
    in_acc   = act && cyc >= ta + 2 && cyc <= ta + 1 + acc_n;
    k        = cyc - (ta + 2);
    i_ready  = in_acc && (k == cur.waits);
    i_rdata  = i_ready ? cur.rdata : $urandom;
    i_slverr = i_ready ? cur.slverr : 1'($urandom);
    #1;
    exp_sel = act && cyc >= ta + 1 && cyc <= ta + 1 + acc_n;
    exp_en  = act && cyc >= ta + 2 && cyc <= ta + 1 + acc_n;
    free    = !act || cyc >= ta + 2 + acc_n;
    win = -1;
    if (free && v != 2'b00) win = (v == 2'b11) ? 1 - mlast : (v[1] ? 1 : 0);
    exp_rdy = (win < 0) ? 2'b00 : ((win == 1) ? 2'b10 : 2'b01);
    exp_rsp = (act && cyc == ta + 2 + acc_n) ? ((cur_id == 1) ? 2'b10 : 2'b01) : 2'b00;
    chk("req_ready", 64'(o_req_ready), 64'(exp_rdy));
    chk("sel", 64'(o_sel), 64'(exp_sel));
    chk("enable", 64'(o_enable), 64'(exp_en));
    chk("rsp_valid", 64'(o_rsp_valid), 64'(exp_rsp));
    if (exp_sel) begin
      chk("addr", 64'(o_addr), 64'(cur.addr));
      chk("write", 64'(o_write), 64'(cur.write));
      chk("wdata", 64'(o_wdata), 64'(cur.wdata));
      chk("strb", 64'(o_strb), 64'(cur.strb));
      chk("prot", 64'(o_prot), 64'(cur.prot));
    end
    if (exp_rsp != 2'b00) begin
      chk("rsp_rdata", 64'(o_rsp_rdata), (cur_to || cur.write) ? 64'd0 : 64'(cur.rdata));
      chk("rsp_slverr", 64'(o_rsp_slverr), cur_to ? 64'd1 : 64'(cur.slverr));
      act = 0;
    end
    if (o_enable) en_cnt++;
    if (o_req_ready != 2'b00) begin g_id.push_back(o_req_ready[1] ? 1 : 0); g_cyc.push_back(cyc); end
    if (o_rsp_valid != 2'b00) begin
      r_cyc.push_back(cyc); r_vec.push_back(o_rsp_valid); r_rd.push_back(o_rsp_rdata);
      r_err.push_back(o_rsp_slverr); r_en.push_back(en_cnt); en_cnt = 0;
    end
    if (win >= 0) begin
      t = (win == 1) ? q1.pop_front() : q0.pop_front();
      cur = t; cur_id = win; ta = cyc; mlast = win; act = 1;
      cur_to = (t.waits >= TO);
      acc_n  = cur_to ? TO : t.waits + 1;
    end
    @(posedge i_ck);
    @(negedge i_ck);
    cyc++;
  endtask

  task automatic run(input string name);
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || act) && n < 200) begin
      step();
      n++;
    end
    if (n >= 200) chk({name, "_bound"}, 64'(n), 64'd0);
    step();
  endtask

  task automatic do_reset();
    i_rst_n = 1'b0;
    #1;
    chk("rst_sel", 64'(o_sel), 64'd0);
    chk("rst_enable", 64'(o_enable), 64'd0);
    chk("rst_rsp_valid", 64'(o_rsp_valid), 64'd0);
    @(negedge i_ck);
    chk("rst_hold_rsp", 64'(o_rsp_valid), 64'd0);
    i_rst_n = 1'b1;
    act = 0; mlast = 1; en_cnt = 0;
    q0.delete(); q1.delete();
  endtask

  int gb, rb;

  initial begin
    i_req_valid = 2'b00; i_req_addr = '0; i_req_write = '0; i_req_wdata = '0;
    i_req_strb = '0; i_req_prot = '0; i_rdata = '0; i_ready = 1'b0; i_slverr = 1'b0;
    #2;
    chk("reset_sel", 64'(o_sel), 64'd0);
    chk("reset_enable", 64'(o_enable), 64'd0);
    chk("reset_rsp_valid", 64'(o_rsp_valid), 64'd0);
    chk("reset_rsp_rdata", 64'(o_rsp_rdata), 64'd0);
    chk("reset_rsp_slverr", 64'(o_rsp_slverr), 64'd0);
    chk("reset_addr", 64'(o_addr), 64'd0);
    chk("reset_wdata", 64'(o_wdata), 64'd0);
    chk("reset_strb_prot_wr", 64'({o_strb, o_prot, o_write}), 64'd0);
    chk("reset_req_ready", 64'(o_req_ready), 64'd0);
    @(negedge i_ck);
    i_rst_n = 1'b1;
    step();

    // single read
    gb = g_cyc.size(); rb = r_cyc.size();
    q0.push_back(mk(12'h010, 1'b0, 32'h0, 4'hF, 3'b000, 0, 32'hDEADBEEF, 1'b0));
    run("single_read");
    chk("rd_nrsp", 64'(r_cyc.size() - rb), 64'd1);
    if (r_cyc.size() > rb && g_cyc.size() > gb) begin
      chk("rd_latency", 64'(r_cyc[rb] - g_cyc[gb]), 64'd3);
      chk("rd_vec", 64'(r_vec[rb]), 64'd1);
      chk("rd_rdata", 64'(r_rd[rb]), 64'hDEADBEEF);
      chk("rd_slverr", 64'(r_err[rb]), 64'd0);
    end

    // contention from reset
    do_reset();
    gb = g_id.size();
    for (int i = 0; i < 2; i++) begin
      q0.push_back(mk(12'h100 + 12'(i), 1'b0, 32'h0, 4'hF, 3'b001, 0, 32'h1000 + 32'(i), 1'b0));
      q1.push_back(mk(12'h200 + 12'(i), 1'b1, 32'hABC0 + 32'(i), 4'h3, 3'b110, 0, 32'h0, 1'b0));
    end
    run("contention");
    chk("rr_ngrants", 64'(g_id.size() - gb), 64'd4);
    if (g_id.size() >= gb + 4) begin
      chk("rr_g0", 64'(g_id[gb]), 64'd0);
      chk("rr_g1", 64'(g_id[gb+1]), 64'd1);
      chk("rr_g2", 64'(g_id[gb+2]), 64'd0);
      chk("rr_g3", 64'(g_id[gb+3]), 64'd1);
    end

    // write with 3 waits
    rb = r_cyc.size();
    q1.push_back(mk(12'h0AA, 1'b1, 32'h12345678, 4'b0101, 3'b010, 3, 32'hFFFF0000, 1'b0));
    run("write_waits");
    if (r_cyc.size() > rb) begin
      chk("wr_access_cycles", 64'(r_en[rb]), 64'd4);
      chk("wr_vec", 64'(r_vec[rb]), 64'd2);
      chk("wr_rdata", 64'(r_rd[rb]), 64'd0);
      chk("wr_slverr", 64'(r_err[rb]), 64'd0);
    end else chk("wr_nrsp", 64'd0, 64'd1);

    // timeout
    rb = r_cyc.size();
    q0.push_back(mk(12'h3C0, 1'b0, 32'h0, 4'hF, 3'b000, 10, 32'h55, 1'b0));
    run("timeout");
    if (r_cyc.size() > rb) begin
      chk("to_access_cycles", 64'(r_en[rb]), 64'd4);
      chk("to_vec", 64'(r_vec[rb]), 64'd1);
      chk("to_rdata", 64'(r_rd[rb]), 64'd0);
      chk("to_slverr", 64'(r_err[rb]), 64'd1);
    end else chk("to_nrsp", 64'd0, 64'd1);

    // slave error
    rb = r_cyc.size();
    q1.push_back(mk(12'h044, 1'b0, 32'h0, 4'hF, 3'b100, 1, 32'hA5A5A5A5, 1'b1));
    run("slverr");
    if (r_cyc.size() > rb) begin
      chk("se_vec", 64'(r_vec[rb]), 64'd2);
      chk("se_slverr", 64'(r_err[rb]), 64'd1);
      chk("se_rdata", 64'(r_rd[rb]), 64'hA5A5A5A5);
    end else chk("se_nrsp", 64'd0, 64'd1);

    // reset in ACCESS, after requester 0 was granted last
    rb = r_cyc.size();
    q0.push_back(mk(12'h0F0, 1'b0, 32'h0, 4'hF, 3'b000, 10, 32'h77, 1'b0));
    for (int i = 0; i < 3; i++) step();
    chk("mid_in_access", 64'(o_enable), 64'd1);
    do_reset();
    chk("mid_no_rsp", 64'(r_cyc.size() - rb), 64'd0);
    gb = g_id.size();
    q0.push_back(mk(12'h011, 1'b0, 32'h0, 4'hF, 3'b000, 0, 32'h9, 1'b0));
    q1.push_back(mk(12'h022, 1'b0, 32'h0, 4'hF, 3'b000, 0, 32'h8, 1'b0));
    run("post_reset");
    if (g_id.size() > gb) chk("post_rst_tie", 64'(g_id[gb]), 64'd0);
    else chk("post_rst_ngrants", 64'd0, 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout cycle %0d: got running expected finished", cyc);
    $fatal(1, "timeout");
  end
endmodule
